// File: rtl/uart_packet_send_if.sv
// Packet-sender bus: payload/length/start from control, UART TX status in, byte launch out.
// Latency: none, wiring only.
// Backpressure: none here; the sender waits on uart_tx_idle / uart_tx_done.
interface uart_packet_send_if #(
  parameter int max_bytes = 16,
  parameter int len_w     = $clog2(max_bytes + 1)
);
  logic [max_bytes*8-1:0] pkt_in;
  logic [len_w-1:0]       pkt_len;
  logic                   send_start;
  logic                   abort;
  logic                   uart_tx_done;
  logic                   uart_tx_idle;
  logic [7:0]             uart_data;
  logic                   uart_start;
  logic                   done;
  logic                   err;
  logic                   aborted;
  logic                   idle;

  // Control / UART-status side
  modport master (
    output pkt_in, pkt_len, send_start, abort, uart_tx_done, uart_tx_idle,
    input  uart_data, uart_start, done, err, aborted, idle
  );

  // Packet sender side
  modport slave (
    input  pkt_in, pkt_len, send_start, abort, uart_tx_done, uart_tx_idle,
    output uart_data, uart_start, done, err, aborted, idle
  );
endinterface

// File: rtl/uart_packet_send.sv
// Framed packet sender: optional header, 1..max_bytes payload bytes, optional two's-complement checksum.
// Latency: first uart_start one cycle after accept; each next byte one cycle after uart_tx_done.
// Backpressure: holds off start while UART busy; paces bytes on uart_tx_done; abort cancels at once.
module uart_packet_send #(
  parameter int         max_bytes = 16,
  parameter int         len_w     = $clog2(max_bytes + 1),
  parameter bit         header_en = 1'b1,
  parameter logic [7:0] header    = 8'hA5,
  parameter bit         chk_en    = 1'b1,
  parameter bit         msb_first = 1'b0
) (
  input logic              clk,
  input logic              rst,
  uart_packet_send_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HEAD, DATA, CHK, FINISH} state_t;

  state_t                 state_q;
  logic [max_bytes*8-1:0] pkt_q;
  logic [len_w-1:0]       len_q;
  logic [len_w-1:0]       idx_q;
  logic [7:0]             sum_q;
  logic [7:0]             uart_data_q;
  logic                   uart_start_q;
  logic                   done_q;
  logic                   err_q;
  logic                   aborted_q;

  // Payload byte k in the configured byte order.
  function automatic logic [7:0] pick(input logic [max_bytes*8-1:0] pkt,
                                      input logic [len_w-1:0] k);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < max_bytes; i++) begin
      if (k == len_w'(i)) begin
        b = msb_first ? pkt[(max_bytes-1-i)*8 +: 8] : pkt[i*8 +: 8];
      end
    end
    return b;
  endfunction

  logic [len_w-1:0] idx_d;
  logic             last_byte;
  logic             len_ok;
  logic [7:0]       in_byte0;
  logic [7:0]       q_byte0;
  logic [7:0]       q_byte_d;

  assign idx_d     = idx_q + len_w'(1);
  assign last_byte = (idx_d == len_q);
  assign len_ok    = (bus.pkt_len != '0) && (bus.pkt_len <= len_w'(max_bytes));
  // Without a header the first payload byte goes out on the accept edge,
  // so it has to come straight from the input bus, not the snapshot.
  assign in_byte0  = pick(bus.pkt_in, '0);
  assign q_byte0   = pick(pkt_q, '0);
  assign q_byte_d  = pick(pkt_q, idx_d);

  // Packet FSM with registered UART launch and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pkt_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      uart_data_q  <= '0;
      uart_start_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      uart_start_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      if (state_q != IDLE && bus.abort) begin
        // Abort outranks a coincident uart_tx_done; the byte in flight finishes in the UART.
        state_q   <= IDLE;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.send_start && bus.uart_tx_idle) begin
              if (len_ok) begin
                pkt_q        <= bus.pkt_in;
                len_q        <= bus.pkt_len;
                idx_q        <= '0;
                uart_start_q <= 1'b1;
                if (header_en) begin
                  state_q     <= HEAD;
                  uart_data_q <= header;
                  sum_q       <= '0;
                end else begin
                  state_q     <= DATA;
                  uart_data_q <= in_byte0;
                  sum_q       <= in_byte0;
                end
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          HEAD: begin
            if (bus.uart_tx_done) begin
              state_q      <= DATA;
              uart_data_q  <= q_byte0;
              sum_q        <= q_byte0;
              uart_start_q <= 1'b1;
            end
          end
          DATA: begin
            if (bus.uart_tx_done) begin
              if (last_byte) begin
                if (chk_en) begin
                  // sum_q already holds every payload byte launched so far.
                  state_q      <= CHK;
                  uart_data_q  <= ~sum_q + 8'd1;
                  uart_start_q <= 1'b1;
                end else begin
                  state_q <= FINISH;
                end
              end else begin
                idx_q        <= idx_d;
                uart_data_q  <= q_byte_d;
                sum_q        <= sum_q + q_byte_d;
                uart_start_q <= 1'b1;
              end
            end
          end
          CHK: begin
            if (bus.uart_tx_done) begin
              state_q <= FINISH;
            end
          end
          FINISH: begin
            if (bus.uart_tx_idle) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.uart_data  = uart_data_q;
  assign bus.uart_start = uart_start_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.aborted    = aborted_q;
  assign bus.idle       = (state_q == IDLE);

endmodule

// File: tb/tb_uart_packet_send.sv
// Directed bench for uart_packet_send: default framing and an MSB-first, header/checksum-free variant.
// Inputs are driven 3 time units after each rising edge; a monitor logs launched bytes on the falling edge.
module tb_uart_packet_send;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done0, err0, ab0, done1;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  uart_packet_send_if #(.max_bytes(16)) if0 ();
  uart_packet_send_if #(.max_bytes(4))  if1 ();

  uart_packet_send #(.max_bytes(16)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  uart_packet_send #(.max_bytes(4), .header_en(1'b0), .chk_en(1'b0), .msb_first(1'b1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch / pulse monitor
  always @(negedge clk) begin
    if (if0.uart_start === 1'b1) q0.push_back(if0.uart_data);
    if (if1.uart_start === 1'b1) q1.push_back(if1.uart_data);
    if (if0.done === 1'b1) done0++;
    if (if0.err === 1'b1) err0++;
    if (if0.aborted === 1'b1) ab0++;
    if (if1.done === 1'b1) done1++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic drv_uart(input bit sel, input logic idle_v, input logic done_v, input logic abort_v);
    if (sel) begin
      if1.uart_tx_idle = idle_v; if1.uart_tx_done = done_v; if1.abort = abort_v;
    end else begin
      if0.uart_tx_idle = idle_v; if0.uart_tx_done = done_v; if0.abort = abort_v;
    end
  endtask

  // Plays the UART: accepts n launches, answers each with uart_tx_done after 4 cycles.
  // abort_at selects the byte whose done coincides with abort (-1 for none).
  task automatic serve(input bit sel, input int n, input int abort_at);
    int waited;
    for (int b = 0; b < n; b++) begin
      waited = 0;
      while (!(sel ? if1.uart_start : if0.uart_start) && waited < 20) begin
        tick();
        waited++;
      end
      checks++;
      if (waited >= 20) begin
        errors++;
        $display("FAIL start_timeout dut%0d byte %0d: no uart_start within 20 cycles", sel, b);
        return;
      end
      if (b > 0) begin
        checks++;
        if (waited != 0) begin
          errors++;
          $display("FAIL turnaround dut%0d byte %0d: waited %0d cycles, want 0", sel, b, waited);
        end
      end
      drv_uart(sel, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      drv_uart(sel, 1'b0, 1'b1, b == abort_at);
      tick();
      drv_uart(sel, (b == n - 1) && (b != abort_at), 1'b0, 1'b0);
      if (b == abort_at) return;
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (if0.uart_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", if0.uart_data); end
    checks++; if (if0.uart_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", if0.uart_start); end
    checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", if0.done); end
    checks++; if (if0.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", if0.err); end
    checks++; if (if0.aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %b want 0", if0.aborted); end
    checks++; if (if0.idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", if0.idle); end
    checks++; if (if1.idle !== 1'b1) begin errors++; $display("FAIL reset_idle1: got %b want 1", if1.idle); end
    rst = 1'b0;
    tick();
    checks++; if (if0.idle !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got %b want 1", if0.idle); end
  endtask

  task automatic test_defaults();
    logic [7:0] exp [5];
    exp = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'hFA};
    q0.delete(); done0 = 0;
    if0.pkt_in = 128'h030201; if0.pkt_len = 5'd3; if0.send_start = 1'b1;
    tick();
    if0.send_start = 1'b0;
    checks++; if (if0.uart_start !== 1'b1 || if0.uart_data !== 8'hA5) begin errors++; $display("FAIL first_launch: start %b data %h, want 1 a5", if0.uart_start, if0.uart_data); end
    serve(1'b0, 5, -1);
    tick();
    checks++; if (if0.done !== 1'b1 || if0.idle !== 1'b1) begin errors++; $display("FAIL defaults_done: done %b idle %b, want 1 1", if0.done, if0.idle); end
    repeat (3) tick();
    checks++; if (q0.size() != 5) begin errors++; $display("FAIL defaults_count: got %0d starts want 5", q0.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= q0.size() || q0[i] !== exp[i]) begin errors++; $display("FAIL defaults_byte%0d: got %h want %h", i, (i < q0.size()) ? q0[i] : 8'hxx, exp[i]); end
    end
    checks++; if (done0 != 1) begin errors++; $display("FAIL defaults_done_count: got %0d want 1", done0); end
  endtask

  task automatic test_msb_first();
    q1.delete(); done1 = 0;
    if1.pkt_in = 32'h11223344; if1.pkt_len = 3'd2; if1.send_start = 1'b1;
    tick();
    if1.send_start = 1'b0;
    checks++; if (if1.uart_start !== 1'b1 || if1.uart_data !== 8'h11) begin errors++; $display("FAIL msb_first_launch: start %b data %h, want 1 11", if1.uart_start, if1.uart_data); end
    serve(1'b1, 2, -1);
    tick();
    checks++; if (if1.done !== 1'b1) begin errors++; $display("FAIL msb_done: got %b want 1", if1.done); end
    repeat (3) tick();
    checks++; if (q1.size() != 2) begin errors++; $display("FAIL msb_count: got %0d starts want 2", q1.size()); end
    checks++; if (q1.size() < 2 || q1[0] !== 8'h11 || q1[1] !== 8'h22) begin errors++; $display("FAIL msb_bytes: got %p want 11,22", q1); end
    checks++; if (done1 != 1) begin errors++; $display("FAIL msb_done_count: got %0d want 1", done1); end
  endtask

  task automatic test_bad_len();
    int e0;
    q0.delete(); e0 = err0;
    if0.pkt_len = 5'd0; if0.send_start = 1'b1;
    tick();
    if0.send_start = 1'b0;
    checks++; if (if0.err !== 1'b1) begin errors++; $display("FAIL err_len0: got %b want 1", if0.err); end
    checks++; if (if0.idle !== 1'b1) begin errors++; $display("FAIL err_len0_idle: got %b want 1", if0.idle); end
    tick();
    checks++; if (if0.err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b want 0", if0.err); end
    if0.pkt_len = 5'd17; if0.send_start = 1'b1;
    tick();
    if0.send_start = 1'b0;
    checks++; if (if0.err !== 1'b1) begin errors++; $display("FAIL err_len17: got %b want 1", if0.err); end
    repeat (3) tick();
    checks++; if (err0 - e0 != 2) begin errors++; $display("FAIL err_count: got %0d want 2", err0 - e0); end
    checks++; if (q0.size() != 0) begin errors++; $display("FAIL err_no_start: got %0d starts want 0", q0.size()); end
    checks++; if (if0.idle !== 1'b1) begin errors++; $display("FAIL err_idle: got %b want 1", if0.idle); end
  endtask

  task automatic test_abort();
    int e0;
    q0.delete(); done0 = 0; ab0 = 0; e0 = err0;
    if0.pkt_in = 128'h0504030201; if0.pkt_len = 5'd5; if0.send_start = 1'b1;
    tick();
    if0.send_start = 1'b0;
    serve(1'b0, 5, 1);
    checks++; if (if0.aborted !== 1'b1 || if0.uart_start !== 1'b0) begin errors++; $display("FAIL abort_pulse: aborted %b start %b, want 1 0", if0.aborted, if0.uart_start); end
    checks++; if (if0.idle !== 1'b1) begin errors++; $display("FAIL abort_idle: got %b want 1", if0.idle); end
    if0.abort = 1'b1;
    tick();
    if0.abort = 1'b0;
    checks++; if (if0.aborted !== 1'b0) begin errors++; $display("FAIL abort_in_idle: got %b want 0", if0.aborted); end
    // UART still finishing the aborted byte: start must wait without error.
    if0.pkt_in = 128'h7F; if0.pkt_len = 5'd1; if0.send_start = 1'b1;
    repeat (3) tick();
    checks++; if (q0.size() != 2 || done0 != 0 || ab0 != 1) begin errors++; $display("FAIL abort_after: starts %0d done %0d aborted %0d, want 2 0 1", q0.size(), done0, ab0); end
    checks++; if (err0 != e0) begin errors++; $display("FAIL abort_holdoff_err: got %0d extra errs want 0", err0 - e0); end
    if0.uart_tx_idle = 1'b1;
    tick();
    if0.send_start = 1'b0;
    checks++; if (if0.uart_start !== 1'b1) begin errors++; $display("FAIL abort_restart: got %b want 1", if0.uart_start); end
    serve(1'b0, 3, -1);
    tick();
    checks++; if (if0.done !== 1'b1) begin errors++; $display("FAIL abort_restart_done: got %b want 1", if0.done); end
    checks++; if (q0.size() != 5 || q0[2] !== 8'hA5 || q0[3] !== 8'h7F || q0[4] !== 8'h81) begin errors++; $display("FAIL abort_restart_bytes: got %p want a5,01,a5,7f,81", q0); end
  endtask

  task automatic test_hold_off();
    int e0;
    q0.delete(); done0 = 0; e0 = err0;
    if0.uart_tx_idle = 1'b0;
    if0.pkt_in = 128'hBBAA; if0.pkt_len = 5'd2; if0.send_start = 1'b1;
    repeat (10) tick();
    checks++; if (q0.size() != 0 || err0 != e0 || if0.idle !== 1'b1) begin errors++; $display("FAIL holdoff: starts %0d errs %0d idle %b, want 0 0 1", q0.size(), err0 - e0, if0.idle); end
    if0.uart_tx_idle = 1'b1;
    tick();
    if0.send_start = 1'b0;
    checks++; if (if0.uart_start !== 1'b1) begin errors++; $display("FAIL holdoff_accept: got %b want 1", if0.uart_start); end
    if0.pkt_in = 128'hFFFF; if0.pkt_len = 5'd7;
    serve(1'b0, 4, -1);
    tick();
    checks++; if (if0.done !== 1'b1) begin errors++; $display("FAIL holdoff_done: got %b want 1", if0.done); end
    checks++; if (q0.size() != 4 || q0[0] !== 8'hA5 || q0[1] !== 8'hAA || q0[2] !== 8'hBB || q0[3] !== 8'h9B) begin errors++; $display("FAIL latched_bytes: got %p want a5,aa,bb,9b", q0); end
  endtask

  task automatic test_async_reset();
    q0.delete(); done0 = 0;
    if0.pkt_in = 128'h030201; if0.pkt_len = 5'd3; if0.send_start = 1'b1;
    tick();
    if0.send_start = 1'b0;
    drv_uart(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    drv_uart(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drv_uart(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (if0.uart_start !== 1'b1 || if0.uart_data !== 8'h01) begin errors++; $display("FAIL pre_reset_launch: start %b data %h, want 1 01", if0.uart_start, if0.uart_data); end
    #1 rst = 1'b1;
    #1;
    checks++; if (if0.uart_start !== 1'b0 || if0.uart_data !== 8'h00) begin errors++; $display("FAIL async_rst_launch: start %b data %h, want 0 00", if0.uart_start, if0.uart_data); end
    checks++; if (if0.idle !== 1'b1 || if0.done !== 1'b0 || if0.err !== 1'b0 || if0.aborted !== 1'b0) begin errors++; $display("FAIL async_rst_status: idle %b done %b err %b aborted %b, want 1 0 0 0", if0.idle, if0.done, if0.err, if0.aborted); end
    tick();
    rst = 1'b0;
    if0.uart_tx_idle = 1'b1;
    tick();
    q0.delete(); done0 = 0;
    if0.pkt_in = 128'h10; if0.pkt_len = 5'd1; if0.send_start = 1'b1;
    tick();
    if0.send_start = 1'b0;
    serve(1'b0, 3, -1);
    tick();
    checks++; if (if0.done !== 1'b1) begin errors++; $display("FAIL post_rst_done: got %b want 1", if0.done); end
    checks++; if (q0.size() != 3 || q0[0] !== 8'hA5 || q0[1] !== 8'h10 || q0[2] !== 8'hF0) begin errors++; $display("FAIL post_rst_bytes: got %p want a5,10,f0", q0); end
  endtask

  initial begin
    checks = 0; errors = 0;
    done0 = 0; err0 = 0; ab0 = 0; done1 = 0;
    rst = 1'b1;
    if0.pkt_in = '0; if0.pkt_len = '0; if0.send_start = 1'b0; if0.abort = 1'b0;
    if0.uart_tx_done = 1'b0; if0.uart_tx_idle = 1'b1;
    if1.pkt_in = '0; if1.pkt_len = '0; if1.send_start = 1'b0; if1.abort = 1'b0;
    if1.uart_tx_done = 1'b0; if1.uart_tx_idle = 1'b1;
    test_reset();
    test_defaults();
    test_msb_first();
    test_bad_len();
    test_abort();
    test_hold_off();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_packet_send.md
# uart_packet_send

Parametrised packet transmitter that feeds a byte-level UART TX core. On a start request it snapshots a payload of 1..`max_bytes` bytes with a runtime length, then sends an optional header byte, the payload (LSB-first or MSB-first), and an optional two's-complement checksum, one byte per UART completion. It sits between the control logic of the smart-car FPGA design and the UART TX core, and replaces fixed-length string senders wherever variable-length framed telemetry is needed.

## Interface
- `max_bytes`, 16: payload capacity in bytes (≥1)
- `len_w`, `$clog2(max_bytes+1)`: width of `pkt_len`
- `header_en`, 1: 1 = send `header` byte before payload
- `header`, 8'hA5: header byte value
- `chk_en`, 1: 1 = append checksum byte after payload
- `msb_first`, 0: payload byte order (see Operation)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `pkt_in`  in  `max_bytes*8`  payload, sampled only on accept
- `pkt_len`  in  `len_w`  payload byte count, sampled on accept
- `send_start`  in  1  request; level or pulse, acted on only in IDLE
- `abort`  in  1  cancel packet in progress
- `uart_tx_done`  in  1  1-cycle pulse from UART TX: byte finished
- `uart_tx_idle`  in  1  UART TX idle level
- `uart_data`  out  8  byte for UART TX, registered, valid while `uart_start` high and held until the next launch
- `uart_start`  out  1  1-cycle launch pulse to UART TX
- `done`  out  1  1-cycle pulse: packet fully sent
- `err`  out  1  1-cycle pulse: start rejected (bad length)
- `aborted`  out  1  1-cycle pulse: packet cancelled
- `idle`  out  1  combinational, high in IDLE

## Operation
- States: IDLE, HEAD, DATA, CHK, FINISH.
- Accept: IDLE & `send_start` & `uart_tx_idle` & 1≤`pkt_len`≤`max_bytes`. On accept, latch `pkt_in` and `pkt_len`, clear the byte index and checksum, and go to HEAD (`header_en`=1) or DATA. The first byte is launched on the same edge.
- Reject: IDLE & `send_start` & `uart_tx_idle` & (`pkt_len`=0 or >`max_bytes`). Pulse `err` and stay in IDLE. `send_start` while `uart_tx_idle`=0 is held off without error.
- Payload byte k (0..len-1): `msb_first`=0 uses `pkt[8k+7:8k]`; `msb_first`=1 uses `pkt[(max_bytes-k)*8-1 -: 8]`.
- Checksum: the 8-bit running sum (mod 256) of the payload bytes only. Transmitted value = (~sum+1) mod 256, so payload plus checksum sums to 0 mod 256.
- Advance on `uart_tx_done` in HEAD/DATA/CHK:
  - HEAD → DATA.
  - DATA with more payload bytes left → DATA, index+1.
  - Last payload byte → CHK (`chk_en`=1) or FINISH.
  - CHK → FINISH.
  - Every transition except the one into FINISH launches the next byte.
- FINISH: when `uart_tx_idle`=1, pulse `done` and go to IDLE.
- Abort: `abort`=1 in any non-IDLE state goes to IDLE on the next edge and pulses `aborted`. No further `uart_start`, no `done`. A byte already in the UART completes on its own.
- Abort in IDLE is ignored. `uart_tx_done` in IDLE or FINISH is ignored.
- Total `uart_start` pulses per packet = `header_en` + `pkt_len` + `chk_en`.

## Timing
- Reset values: state IDLE, `uart_data`=0, `uart_start`=0, `done`=0, `err`=0, `aborted`=0, `idle`=1, index=0, checksum=0.
- Accept edge N: `uart_start`=1 and first `uart_data` valid in cycle N+1.
- `uart_tx_done` seen at edge M: next `uart_start` and `uart_data` are valid in cycle M+1 (1-cycle turnaround).
- `done` is high in the cycle after the edge where FINISH sees `uart_tx_idle`; `idle` rises in the same cycle.
- `err` and `aborted` are high for exactly one cycle after the deciding edge.
- Priority in the same cycle: `abort` > `uart_tx_done`.
- `pkt_in` and `pkt_len` may change freely after accept. Only the latched copy is used.
- Async `rst` mid-packet returns all outputs to reset values immediately. `uart_start` must never be left high.

## Test plan
- Defaults, `pkt_len`=3, `pkt_in[23:0]`=24'h030201 -> `uart_data` sequence A5,01,02,03,FA; 5 `uart_start` pulses; one `done` after the last `uart_tx_idle`.
- `msb_first`=1, `max_bytes`=4, `header_en`=0, `chk_en`=0, `pkt_in`=32'h11223344, `pkt_len`=2 -> sequence 11,22; 2 pulses; `done`.
- `pkt_len`=0, then `pkt_len`=17 (`max_bytes`=16) with `send_start` -> `err` pulses once each; no `uart_start`; `idle` stays 1.
- `abort` raised in the same cycle as the 2nd `uart_tx_done` of a 5-byte packet -> `aborted` pulse, no 3rd `uart_start`, no `done`; a new start is accepted once `uart_tx_idle`=1.
- `send_start` held high with `uart_tx_idle`=0 for 10 cycles, then `uart_tx_idle`=1 -> accept on the first idle cycle. `pkt_in` changed right after accept -> transmitted bytes match the latched value.
- `rst` asserted asynchronously mid-DATA -> all outputs at reset values before the next clock edge. After release, a normal 1-byte packet (A5,xx,chk) completes correctly.
